mem_responder: RTL
==================

Name: mem_responder

Overview:
- Data-memory responder servicing load/store requests from a memory functional unit.
- Accepts one request per transaction through a req/ready handshake.
- Models a fixed access latency, performs byte/half/word access with sign/zero extension, and returns a one-cycle response pulse with load data and a misalignment error flag.
- Sits between the memory FU and the word-organised data store.

Parameters:
- DEPTH_LOG2, 10, log2 of number of 32-bit words in the array (word index = addr[DEPTH_LOG2+1:2]).
- LATENCY, 2, cycles from request acceptance to resp_valid (must be >= 1).

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- req  input  1  request valid
- ready  output  1  responder idle, can accept a request this cycle
- mem_w  input  1  1 = store, 0 = load
- bhw  input  3  access type, RV funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal
- addr  input  32  byte address
- wdata  input  32  store data (low byte/half used for B/H)
- resp_valid  output  1  one-cycle pulse: transaction complete
- rdata  output  32  load result, valid while resp_valid=1, 0 for stores/errors
- err  output  1  valid with resp_valid: misaligned or illegal bhw

Behaviour:
- Reset, synchronous, active-high:
  - state=IDLE, ready=1, resp_valid=0, rdata=0, err=0, counter=0.
  - Array contents are not cleared.
  - Reset during BUSY aborts the transaction: no store is committed and no response is issued.
- FSM states:
  - IDLE:
    - ready=1.
    - On req=1 at an edge, latch mem_w, bhw, addr, wdata.
    - Load counter with LATENCY-1 and go to BUSY.
    - If LATENCY=1, go directly to RESP.
  - BUSY:
    - ready=0; req is ignored and not queued.
    - Counter decrements each cycle.
    - When the counter reaches 1, the next state is RESP.
  - RESP:
    - resp_valid=1 for exactly one cycle.
    - ready=0 in this cycle; next state is IDLE.
    - The next request is accepted no earlier than the following cycle.
- Timing: request accepted at edge T → resp_valid high in the cycle after edge T+LATENCY-1, i.e. LATENCY cycles after acceptance. Throughput is one transaction per LATENCY+1 cycles.
- Error check, evaluated on latched fields:
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=00.
  - Illegal: bhw not in {000,001,010,100,101}; a store with bhw[2]=1 is also illegal.
  - On error: err=1, rdata=0, no array write.
- Store, no error:
  - Committed at the edge entering RESP.
  - Byte lanes are selected by addr[1:0]: B writes 1 lane, H writes lanes {addr[1],0} and {addr[1],1}, W writes all 4.
  - Other bytes of the word are unchanged.
  - rdata=0 and err=0 with the response.
- Load, no error:
  - The word is read from the array during BUSY/RESP; the lane is selected by addr[1:0].
  - B/H are sign-extended; BU/HU are zero-extended.
  - Little-endian: byte 0 is bits [7:0].
- Address range: upper address bits above DEPTH_LOG2+1 are ignored, so the array wraps modulo 4·2^DEPTH_LOG2 bytes.
- Output timing: rdata and err are registered and are driven only during RESP; they are 0 otherwise.

Test Plan:
- Reset then SW addr=0x10 wdata=0xDEADBEEF → resp_valid exactly LATENCY cycles after acceptance, err=0, rdata=0. Then LW addr=0x10 → rdata=0xDEADBEEF.
- Word at 0x20 = 0x80FF7F01:
  - LB 0x23 → 0xFFFFFF80; LBU 0x23 → 0x00000080; LB 0x20 → 0x00000001.
  - LH 0x22 → 0xFFFF80FF; LHU 0x22 → 0x000080FF.
- Word at 0x30 = 0x11223344:
  - SB 0x31 wdata=0xAA → LW 0x30 returns 0x1122AA44.
  - SH 0x32 wdata=0xBEEF → LW 0x30 returns 0xBEEFAA44.
- Misaligned and illegal requests:
  - LW 0x41 → err=1, rdata=0.
  - SH 0x43 → err=1; a following LW 0x40 shows the word unchanged.
  - bhw=011 → err=1.
- Handshake and reset:
  - Hold req=1 continuously: ready=0 throughout BUSY/RESP, only one transaction per LATENCY+1 cycles, no duplicate response.
  - Assert rst one cycle after accepting SW 0x50 wdata=0x12345678 → no resp_valid; LW 0x50 returns the prior contents.
- Wrap-around: SW to addr 0x0000_0010 + (4<<DEPTH_LOG2) → LW 0x10 returns the stored value.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder
// Data-memory responder for the memory functional unit. It accepts one
// load/store at a time, waits a fixed LATENCY, then pulses resp_valid for
// one cycle with the load result and a misalignment/illegal-access flag.
//
// Handshake: a request is accepted on a rising edge where req=1 and
// ready=1. While the transaction is in flight, ready stays 0. A req seen
// while ready=0 is ignored, not queued. The response is a single-cycle
// resp_valid pulse, and no backpressure is applied to it. ready goes back
// to 1 in the cycle after the pulse.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset; aborts an in-flight access
//   req        request valid
//   ready      idle, a request may be accepted this cycle
//   mem_w      1 = store, 0 = load
//   bhw        access type, RV funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   addr       byte address; bits above DEPTH_LOG2+1 are ignored (wraps)
//   wdata      store data, low byte/half used for B/H
//   resp_valid one-cycle completion pulse
//   rdata      load result during the pulse, 0 otherwise and for stores/errors
//   err        misaligned or illegal access, valid during the pulse
module mem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    output logic        ready,
    input  logic        mem_w,
    input  logic [2:0]  bhw,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int AW    = DEPTH_LOG2 + 2;
    localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // The state register is named and typed so checkers can bind to it.
    state_t state;

    logic [CW-1:0] cnt;
    logic          l_w;
    logic [2:0]    l_bhw;
    logic [AW-1:0] l_addr;
    logic [31:0]   l_wdata;

    logic [31:0] mem [DEPTH];

    // Address bits above the array are ignored by design.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:AW];

    // Effective transaction fields. With LATENCY=1 the response is produced
    // on the accepting edge, so the fields come straight from the ports.
    logic          e_w;
    logic [2:0]    e_bhw;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_wdata;

    always_comb begin
        e_w     = l_w;
        e_bhw   = l_bhw;
        e_addr  = l_addr;
        e_wdata = l_wdata;
        if (state == IDLE) begin
            e_w     = mem_w;
            e_bhw   = bhw;
            e_addr  = addr[AW-1:0];
            e_wdata = wdata;
        end
    end

    logic enter_resp;
    assign enter_resp = ((state == IDLE) && req && (LATENCY == 1)) ||
                        ((state == BUSY) && (cnt == CW'(1)));

    // Error detection
    logic e_misalign, e_illegal, e_err;
    always_comb begin
        e_misalign = 1'b0;
        e_illegal  = 1'b0;
        case (e_bhw)
            3'b000, 3'b100: e_misalign = 1'b0;
            3'b001, 3'b101: e_misalign = e_addr[0];
            3'b010:         e_misalign = (e_addr[1:0] != 2'b00);
            default:        e_illegal  = 1'b1;
        endcase
        // Unsigned variants only make sense for loads.
        if (e_w && e_bhw[2]) e_illegal = 1'b1;
        e_err = e_misalign || e_illegal;
    end

    // Load path: lane select plus sign/zero extension.
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0]           rd_word;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [31:0]           load_val;
    logic [31:0]           resp_data;

    assign idx     = e_addr[AW-1:2];
    assign rd_word = mem[idx];
    assign rd_byte = rd_word[8*e_addr[1:0] +: 8];
    assign rd_half = e_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (e_bhw)
            3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_val = {24'd0, rd_byte};
            3'b101:  load_val = {16'd0, rd_half};
            default: load_val = rd_word;
        endcase
        resp_data = (!e_w && !e_err) ? load_val : 32'd0;
    end

    // Store path: replicate data across lanes, then enable only the
    // addressed lanes.
    logic [3:0]  be;
    logic [31:0] wd;
    always_comb begin
        case (e_bhw[1:0])
            2'b00: begin
                be = 4'b0001 << e_addr[1:0];
                wd = {4{e_wdata[7:0]}};
            end
            2'b01: begin
                be = e_addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{e_wdata[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = e_wdata;
            end
        endcase
    end

    logic commit;
    assign commit = enter_resp && e_w && !e_err && !rst;

    // The array is never reset. A reset in flight suppresses the commit.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ready      <= 1'b1;
            resp_valid <= 1'b0;
            rdata      <= 32'd0;
            err        <= 1'b0;
            cnt        <= '0;
            l_w        <= 1'b0;
            l_bhw      <= 3'd0;
            l_addr     <= '0;
            l_wdata    <= 32'd0;
        end else begin
            // Response outputs are non-zero only in the RESP cycle.
            resp_valid <= 1'b0;
            rdata      <= 32'd0;
            err        <= 1'b0;
            if (enter_resp) begin
                resp_valid <= 1'b1;
                rdata      <= resp_data;
                err        <= e_err;
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        l_w     <= mem_w;
                        l_bhw   <= bhw;
                        l_addr  <= addr[AW-1:0];
                        l_wdata <= wdata;
                        cnt     <= CW'(LATENCY - 1);
                        ready   <= 1'b0;
                        state   <= (LATENCY == 1) ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
